// File: rtl/seq_shift_left.sv
// seq_shift_left: iterative multi-cycle logical left shifter (SLL/SLLV path).
// Accepts one operand/shift amount over a valid/ready handshake, shifts left
// by up to STEP bits per cycle, then holds the result until it is consumed.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand offer
//   in_ready   block can accept (IDLE only, decoded from state)
//   a          operand, sampled on accept
//   shift      shift amount 0..WIDTH-1, sampled on accept
//   out_valid  result available (DONE only, decoded from state)
//   out_ready  consumer takes result
//   out        result (registered accumulator)
//   busy       registered state != IDLE
module seq_shift_left #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   rem_q, rem_d;
    logic             busy_q;

    // State, accumulator and remaining-shift registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    acc_d   = a;
                    rem_d   = shift;
                    state_d = (shift == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Full step while enough remains; the final partial step
                // consumes whatever is left so the total is exactly n bits.
                if (rem_q >= STEP_W) begin
                    acc_d = acc_q << STEP;
                    rem_d = rem_q - STEP_W;
                end else begin
                    acc_d = acc_q << rem_q;
                    rem_d = '0;
                end
                if (rem_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out       = acc_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seq_shift_left.sv
// Testbench for seq_shift_left: one instance per legal STEP (1,2,4,8,16),
// directed table, hand-written corner sequences, and randomized ops checked
// against a plain-arithmetic reference (a << n, ceil(n/STEP) latency).
module tb_seq_shift_left;

    localparam int unsigned NI = 5;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [NI];
    logic [31:0] a_in      [NI];
    logic [4:0]  sh_in     [NI];
    logic        out_ready [NI];
    logic        in_ready_w  [NI];
    logic        out_valid_w [NI];
    logic        busy_w      [NI];
    logic [31:0] out_w       [NI];

    int tests  = 0;
    int errors = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        seq_shift_left #(.WIDTH(32), .SHW(5), .STEP(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready_w[g]),
            .a         (a_in[g]),
            .shift     (sh_in[g]),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready[g]),
            .out       (out_w[g]),
            .busy      (busy_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [4:0]  sh;
        logic [31:0] ex;
        int          lat;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one op at the current negedge, wait for result, consume it
    task automatic run_op(input int idx, input logic [31:0] av, input logic [4:0] sv,
                          input logic [31:0] ev, input int lv, input string nm);
        int cnt;
        chk({nm, " in_ready pre"}, 32'(in_ready_w[idx]), 32'd1);
        in_valid[idx]  = 1'b1;
        a_in[idx]      = av;
        sh_in[idx]     = sv;
        out_ready[idx] = 1'b0;
        @(negedge clk);
        in_valid[idx] = 1'b0;
        cnt = 0;
        while (!out_valid_w[idx] && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk({nm, " latency"}, 32'(cnt), 32'(lv));
        chk({nm, " out"}, out_w[idx], ev);
        chk({nm, " busy"}, 32'(busy_w[idx]), 32'd1);
        out_ready[idx] = 1'b1;
        @(negedge clk);
        out_ready[idx] = 1'b0;
        chk({nm, " in_ready post"}, 32'(in_ready_w[idx]), 32'd1);
        chk({nm, " out_valid post"}, 32'(out_valid_w[idx]), 32'd0);
        chk({nm, " busy post"}, 32'(busy_w[idx]), 32'd0);
    endtask

    // Random ops with random backpressure and junk on ignored inputs
    task automatic rand_ops(input int idx, input int step, input int nops);
        logic [31:0] av, ev;
        logic [4:0]  sv;
        int          lv, cnt, waits;
        logic        r, done;
        for (int k = 0; k < nops; k++) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid[idx] = 1'b0;
                @(negedge clk);
            end
            chk("rand in_ready idle", 32'(in_ready_w[idx]), 32'd1);
            av = $urandom;
            sv = 5'($urandom_range(0, 31));
            ev = av << sv;
            lv = (int'(sv) + step - 1) / step;
            in_valid[idx]  = 1'b1;
            a_in[idx]      = av;
            sh_in[idx]     = sv;
            out_ready[idx] = 1'($urandom_range(0, 1));
            @(negedge clk);
            cnt = 0;
            while (!out_valid_w[idx] && cnt < 100) begin
                in_valid[idx]  = 1'($urandom_range(0, 1));
                a_in[idx]      = $urandom;
                sh_in[idx]     = 5'($urandom);
                out_ready[idx] = 1'($urandom_range(0, 1));
                @(negedge clk);
                cnt++;
            end
            chk("rand latency", 32'(cnt), 32'(lv));
            chk("rand out", out_w[idx], ev);
            done  = 1'b0;
            waits = 0;
            while (!done) begin
                r = (waits > 8) ? 1'b1 : 1'($urandom_range(0, 1));
                out_ready[idx] = r;
                in_valid[idx]  = r ? 1'b0 : 1'($urandom_range(0, 1));
                a_in[idx]      = $urandom;
                @(negedge clk);
                if (r) begin
                    done = 1'b1;
                end else begin
                    chk("rand hold valid", 32'(out_valid_w[idx]), 32'd1);
                    chk("rand hold out", out_w[idx], ev);
                end
                waits++;
            end
            out_ready[idx] = 1'b0;
            chk("rand consumed", 32'(out_valid_w[idx]), 32'd0);
            chk("rand out kept", out_w[idx], ev);
        end
    endtask

    initial begin
        logic [31:0] bp_ex;
        int          cnt;

        tbl[0] = '{0, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 0};
        tbl[1] = '{0, 32'h00000001, 5'd31, 32'h80000000, 31};
        tbl[2] = '{2, 32'hFFFFFFFF, 5'd7,  32'hFFFFFF80, 2};
        tbl[3] = '{0, 32'h12345678, 5'd4,  32'h23456780, 4};
        tbl[4] = '{2, 32'h12345678, 5'd4,  32'h23456780, 1};
        tbl[5] = '{4, 32'h0000ABCD, 5'd17, 32'h579A0000, 2};
        tbl[6] = '{1, 32'h00000003, 5'd31, 32'h80000000, 16};
        tbl[7] = '{3, 32'h000000FF, 5'd24, 32'hFF000000, 3};

        rst_n = 1'b0;
        for (int i = 0; i < int'(NI); i++) begin
            in_valid[i]  = 1'b0;
            a_in[i]      = '0;
            sh_in[i]     = '0;
            out_ready[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < int'(NI); i++) begin
            chk("reset out", out_w[i], 32'd0);
            chk("reset out_valid", 32'(out_valid_w[i]), 32'd0);
            chk("reset busy", 32'(busy_w[i]), 32'd0);
            chk("reset in_ready", 32'(in_ready_w[i]), 32'd1);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].idx, tbl[i].a, tbl[i].sh, tbl[i].ex, tbl[i].lat, $sformatf("vec%0d", i));
        end

        // Backpressure: result held while new operands are offered in DONE
        bp_ex = 32'h2D2D2D28;
        in_valid[0] = 1'b1;
        a_in[0]     = 32'hA5A5A5A5;
        sh_in[0]    = 5'd3;
        @(negedge clk);
        in_valid[0] = 1'b0;
        cnt = 0;
        while (!out_valid_w[0] && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("bp latency", 32'(cnt), 32'd3);
        for (int i = 0; i < 6; i++) begin
            in_valid[0] = (i % 2 == 0);
            a_in[0]     = 32'h11111111;
            sh_in[0]    = 5'd1;
            @(negedge clk);
            chk("bp out stable", out_w[0], bp_ex);
            chk("bp out_valid", 32'(out_valid_w[0]), 32'd1);
            chk("bp in_ready", 32'(in_ready_w[0]), 32'd0);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        chk("bp released", 32'(in_ready_w[0]), 32'd1);
        chk("bp acc kept", out_w[0], bp_ex);
        run_op(0, 32'h11111111, 5'd1, 32'h22222222, 1, "bp next");

        // Abort: asynchronous reset in the middle of SHIFT
        in_valid[0] = 1'b1;
        a_in[0]     = 32'h12345678;
        sh_in[0]    = 5'd20;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort busy before", 32'(busy_w[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort out", out_w[0], 32'd0);
        chk("abort out_valid", 32'(out_valid_w[0]), 32'd0);
        chk("abort busy", 32'(busy_w[0]), 32'd0);
        chk("abort in_ready", 32'(in_ready_w[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid_w[0]) cnt++;
        end
        chk("abort no result", 32'(cnt), 32'd0);
        run_op(0, 32'h12345678, 5'd4, 32'h23456780, 4, "after abort");

        for (int g = 0; g < int'(NI); g++) begin
            rand_ops(g, 1 << g, 500);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
